// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the dual-lane data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int unsigned DefAw = 8;
  localparam int unsigned DefDw = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_req_mux.sv
// 2:1 selector for a memory request bundle {addr, wdata, rd, wr}; sel=1 picks side b.
module dmem_req_mux #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          sel,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          rd_a,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  input  logic          rd_b,
  input  logic          wr_b,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          rd_o,
  output logic          wr_o
);

  always_comb begin
    addr_o  = addr_a;
    wdata_o = wdata_a;
    rd_o    = rd_a;
    wr_o    = wr_a;
    if (sel) begin
      addr_o  = addr_b;
      wdata_o = wdata_b;
      rd_o    = rd_b;
      wr_o    = wr_b;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between two MEM-stage lanes; a dual access is serialised
// (inst1 then inst2) at the cost of a single stall cycle.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en_i1,
  input  logic             wr_en_i1,
  input  logic [AW-1:0]    addr_i1,
  input  logic [DW-1:0]    wdata_i1,
  input  logic             rd_en_i2,
  input  logic             wr_en_i2,
  input  logic [AW-1:0]    addr_i2,
  input  logic [DW-1:0]    wdata_i2,
  input  logic             flush,
  input  logic [DW-1:0]    dmem_rdata,
  output logic [AW-1:0]    dmem_addr,
  output logic [DW-1:0]    dmem_wdata,
  output logic             dmem_rd_en,
  output logic             dmem_wr_en,
  output logic [DW-1:0]    rdata_i1,
  output logic [DW-1:0]    rdata_i2,
  output logic             mem_stall,
  output logic [CNT_W-1:0] conflict_cnt
);

  arb_state_e       state_q;
  logic [AW-1:0]    pend_addr_q;
  logic [DW-1:0]    pend_wdata_q;
  logic             pend_rd_q;
  logic             pend_wr_q;
  logic [DW-1:0]    hold_rdata_q;
  logic [CNT_W-1:0] conflict_cnt_q;

  logic acc1, acc2, rd1_eff, rd2_eff, in_second, dual;

  // A write wins over a simultaneous read on the same lane.
  assign rd1_eff   = rd_en_i1 & ~wr_en_i1;
  assign rd2_eff   = rd_en_i2 & ~wr_en_i2;
  assign acc1      = rd_en_i1 | wr_en_i1;
  assign acc2      = rd_en_i2 | wr_en_i2;
  assign in_second = (state_q == ARB_SECOND);
  assign dual      = ~in_second & acc1 & acc2;

  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_rd, b_wr;

  // Lane-2 side: live inputs in IDLE, the latched request in SECOND.
  dmem_req_mux #(.AW(AW), .DW(DW)) u_lane2_mux (
    .sel     (in_second),
    .addr_a  (addr_i2),
    .wdata_a (wdata_i2),
    .rd_a    (rd2_eff),
    .wr_a    (wr_en_i2),
    .addr_b  (pend_addr_q),
    .wdata_b (pend_wdata_q),
    .rd_b    (pend_rd_q),
    .wr_b    (pend_wr_q),
    .addr_o  (b_addr),
    .wdata_o (b_wdata),
    .rd_o    (b_rd),
    .wr_o    (b_wr)
  );

  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;
  logic          mux_rd, mux_wr;

  dmem_req_mux #(.AW(AW), .DW(DW)) u_out_mux (
    .sel     (in_second | (acc2 & ~acc1)),
    .addr_a  (addr_i1),
    .wdata_a (wdata_i1),
    .rd_a    (rd1_eff),
    .wr_a    (wr_en_i1),
    .addr_b  (b_addr),
    .wdata_b (b_wdata),
    .rd_b    (b_rd),
    .wr_b    (b_wr),
    .addr_o  (mux_addr),
    .wdata_o (mux_wdata),
    .rd_o    (mux_rd),
    .wr_o    (mux_wr)
  );

  assign dmem_addr    = mux_addr;
  assign dmem_wdata   = mux_wdata;
  assign dmem_rd_en   = mux_rd & ~(in_second & flush);
  assign dmem_wr_en   = mux_wr & ~(in_second & flush);
  assign mem_stall    = dual;
  assign conflict_cnt = conflict_cnt_q;

  always_comb begin
    rdata_i1 = '0;
    rdata_i2 = '0;
    if (in_second) begin
      rdata_i1 = hold_rdata_q;
      if (pend_rd_q && !flush) rdata_i2 = dmem_rdata;
    end else begin
      if (rd1_eff) rdata_i1 = dmem_rdata;
      if (rd2_eff && !acc1) rdata_i2 = dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ARB_IDLE;
      pend_addr_q    <= '0;
      pend_wdata_q   <= '0;
      pend_rd_q      <= 1'b0;
      pend_wr_q      <= 1'b0;
      hold_rdata_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (acc1 && acc2) begin
            state_q      <= ARB_SECOND;
            pend_addr_q  <= addr_i2;
            pend_wdata_q <= wdata_i2;
            pend_rd_q    <= rd2_eff;
            pend_wr_q    <= wr_en_i2;
            hold_rdata_q <= rd1_eff ? dmem_rdata : '0;
            if (conflict_cnt_q != '1) conflict_cnt_q <= conflict_cnt_q + 1'b1;
          end
        end
        ARB_SECOND: state_q <= ARB_IDLE;
        default:    state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: directed vector table, reset corner case, and random pairs
// scored against a transaction-level memory model.
module tb_dmem_port_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 3;
  localparam int          SatMax = (1 << SAT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic rd_en_i1, wr_en_i1, rd_en_i2, wr_en_i2, flush;
  logic [AW-1:0] addr_i1, addr_i2, dmem_addr, s_addr;
  logic [DW-1:0] wdata_i1, wdata_i2, dmem_rdata, dmem_wdata, rdata_i1, rdata_i2;
  logic [DW-1:0] s_wdata, s_r1, s_r2;
  logic dmem_rd_en, dmem_wr_en, mem_stall, s_rd, s_wr, s_stall;
  logic [CNT_W-1:0] conflict_cnt;
  logic [SAT_W-1:0] sat_cnt;

  always #5 clk = ~clk;

  // Memory device (environment, not the model).
  logic [DW-1:0] mem [256];
  logic          load_en;
  assign dmem_rdata = mem[dmem_addr];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 32'hAAAA5555;
      mem[8'h04] <= 32'h11;
      mem[8'h08] <= 32'h22;
    end else if (dmem_wr_en) begin
      mem[dmem_addr] <= dmem_wdata;
    end
  end

  dmem_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rd_en_i1(rd_en_i1), .wr_en_i1(wr_en_i1), .addr_i1(addr_i1), .wdata_i1(wdata_i1),
    .rd_en_i2(rd_en_i2), .wr_en_i2(wr_en_i2), .addr_i2(addr_i2), .wdata_i2(wdata_i2),
    .flush(flush), .dmem_rdata(dmem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd_en(dmem_rd_en),
    .dmem_wr_en(dmem_wr_en), .rdata_i1(rdata_i1), .rdata_i2(rdata_i2),
    .mem_stall(mem_stall), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance, used to observe saturation within a short run.
  dmem_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .reset(reset),
    .rd_en_i1(rd_en_i1), .wr_en_i1(wr_en_i1), .addr_i1(addr_i1), .wdata_i1(wdata_i1),
    .rd_en_i2(rd_en_i2), .wr_en_i2(wr_en_i2), .addr_i2(addr_i2), .wdata_i2(wdata_i2),
    .flush(flush), .dmem_rdata(dmem_rdata),
    .dmem_addr(s_addr), .dmem_wdata(s_wdata), .dmem_rd_en(s_rd),
    .dmem_wr_en(s_wr), .rdata_i1(s_r1), .rdata_i2(s_r2),
    .mem_stall(s_stall), .conflict_cnt(sat_cnt)
  );

  typedef struct {
    logic        rd1, wr1;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic        rd2, wr2;
    logic [7:0]  a2;
    logic [31:0] d2;
    logic        fl;
    logic [31:0] e1, e2;
    int          conf;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [256];
  int model_conf = 0;

  task automatic check(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  // Transaction model: inst1 fully completes before inst2; a flushed dual pair drops inst2.
  task automatic model_pair(input vec_t v, output logic [31:0] e1, output logic [31:0] e2);
    logic acc1, acc2, dual;
    acc1 = v.rd1 | v.wr1;
    acc2 = v.rd2 | v.wr2;
    dual = acc1 & acc2;
    e1 = '0;
    e2 = '0;
    if (acc1) begin
      if (v.rd1 && !v.wr1) e1 = ref_mem[v.a1];
      if (v.wr1) ref_mem[v.a1] = v.d1;
    end
    if (acc2 && !(dual && v.fl)) begin
      if (v.rd2 && !v.wr2) e2 = ref_mem[v.a2];
      if (v.wr2) ref_mem[v.a2] = v.d2;
    end
    if (dual && model_conf < 65535) model_conf++;
  endtask

  task automatic run_pair(input vec_t v, input logic [31:0] e1, input logic [31:0] e2,
                          input int conf, input string tag);
    logic a1c, a2c;
    a1c = v.rd1 | v.wr1;
    a2c = v.rd2 | v.wr2;
    @(negedge clk);
    rd_en_i1 = v.rd1; wr_en_i1 = v.wr1; addr_i1 = v.a1; wdata_i1 = v.d1;
    rd_en_i2 = v.rd2; wr_en_i2 = v.wr2; addr_i2 = v.a2; wdata_i2 = v.d2;
    flush = (a1c && a2c) ? 1'b0 : v.fl;
    #1;
    if (a1c && a2c) begin
      check(tag, "stall_c0", mem_stall, 1);
      check(tag, "addr_c0", dmem_addr, v.a1);
      check(tag, "wr_c0", dmem_wr_en, v.wr1);
      check(tag, "rd_c0", dmem_rd_en, v.rd1 & ~v.wr1);
      @(negedge clk);
      flush = v.fl;
      #1;
      check(tag, "stall_c1", mem_stall, 0);
      if (v.fl) begin
        check(tag, "rd_flush", dmem_rd_en, 0);
        check(tag, "wr_flush", dmem_wr_en, 0);
      end else begin
        check(tag, "addr_c1", dmem_addr, v.a2);
        check(tag, "wr_c1", dmem_wr_en, v.wr2);
        check(tag, "rd_c1", dmem_rd_en, v.rd2 & ~v.wr2);
        if (v.wr2) check(tag, "wdata_c1", dmem_wdata, v.d2);
      end
    end else begin
      check(tag, "stall", mem_stall, 0);
      if (a1c) begin
        check(tag, "addr", dmem_addr, v.a1);
        check(tag, "wr", dmem_wr_en, v.wr1);
        check(tag, "rd", dmem_rd_en, v.rd1 & ~v.wr1);
        if (v.wr1) check(tag, "wdata", dmem_wdata, v.d1);
      end else if (a2c) begin
        check(tag, "addr", dmem_addr, v.a2);
        check(tag, "wr", dmem_wr_en, v.wr2);
        check(tag, "rd", dmem_rd_en, v.rd2 & ~v.wr2);
        if (v.wr2) check(tag, "wdata", dmem_wdata, v.d2);
      end else begin
        check(tag, "rd_idle", dmem_rd_en, 0);
        check(tag, "wr_idle", dmem_wr_en, 0);
        check(tag, "addr_idle", dmem_addr, v.a1);
        check(tag, "wdata_idle", dmem_wdata, v.d1);
      end
    end
    check(tag, "rdata_i1", rdata_i1, e1);
    check(tag, "rdata_i2", rdata_i2, e2);
    check(tag, "conflict_cnt", conflict_cnt, conf);
    check(tag, "sat_cnt", sat_cnt, (model_conf > SatMax) ? SatMax : model_conf);
  endtask

  task automatic idle_inputs();
    rd_en_i1 = 0; wr_en_i1 = 0; rd_en_i2 = 0; wr_en_i2 = 0; flush = 0;
    addr_i1 = '0; addr_i2 = '0; wdata_i1 = '0; wdata_i2 = '0;
  endtask

  vec_t tbl [8];
  vec_t v;
  logic [31:0] m1, m2;
  int bad;

  initial begin
    tbl[0] = '{1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0, 32'hAAAA5555, 32'h0, 0};
    tbl[1] = '{1, 0, 8'h04, 32'h0, 1, 0, 8'h08, 32'h0, 0, 32'h11, 32'h22, 1};
    tbl[2] = '{0, 1, 8'h20, 32'hDEADBEEF, 1, 0, 8'h20, 32'h0, 0, 32'h0, 32'hDEADBEEF, 2};
    tbl[3] = '{0, 1, 8'h30, 32'h1, 0, 1, 8'h30, 32'h2, 0, 32'h0, 32'h0, 3};
    tbl[4] = '{0, 0, 8'h00, 32'h0, 1, 0, 8'h08, 32'h0, 1, 32'h0, 32'h22, 3};
    tbl[5] = '{0, 0, 8'h5A, 32'h12345678, 0, 0, 8'h6B, 32'h0, 0, 32'h0, 32'h0, 3};
    tbl[6] = '{1, 1, 8'h40, 32'h5, 0, 0, 8'h00, 32'h0, 0, 32'h0, 32'h0, 3};
    tbl[7] = '{1, 0, 8'h04, 32'h0, 0, 1, 8'h50, 32'h77, 1, 32'h11, 32'h0, 4};

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ref_mem[8'h10] = 32'hAAAA5555;
    ref_mem[8'h04] = 32'h11;
    ref_mem[8'h08] = 32'h22;

    idle_inputs();
    reset   = 1'b0;
    load_en = 1'b1;
    repeat (2) @(posedge clk);
    load_en = 1'b0;
    @(negedge clk);
    check("reset", "stall", mem_stall, 0);
    check("reset", "cnt", conflict_cnt, 0);
    check("reset", "wr", dmem_wr_en, 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      model_pair(tbl[i], m1, m2);
      run_pair(tbl[i], tbl[i].e1, tbl[i].e2, tbl[i].conf, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("post_tbl", "raw_mem", mem[8'h20], 32'hDEADBEEF);
    check("post_tbl", "waw_mem", mem[8'h30], 32'h2);
    check("post_tbl", "rdwr_is_write", mem[8'h40], 32'h5);
    check("post_tbl", "flush_nowrite", mem[8'h50], 32'h0);

    // Reset while the serialised inst2 store is pending.
    rd_en_i1 = 1; addr_i1 = 8'h04; wr_en_i2 = 1; addr_i2 = 8'h60; wdata_i2 = 32'h99;
    #1;
    check("rst_mid", "stall_c0", mem_stall, 1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check("rst_mid", "stall", mem_stall, 0);
    check("rst_mid", "cnt", conflict_cnt, 0);
    check("rst_mid", "sat_cnt", sat_cnt, 0);
    check("rst_mid", "wr", dmem_wr_en, 0);
    model_conf = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid", "wr_after", dmem_wr_en, 0);
    @(negedge clk);
    check("rst_mid", "no_write", mem[8'h60], 32'h0);
    v = '{0, 0, 8'h00, 32'h0, 1, 0, 8'h08, 32'h0, 0, 32'h0, 32'h0, 0};
    model_pair(v, m1, m2);
    run_pair(v, m1, m2, model_conf, "rst_idle");

    for (int i = 0; i < 400; i++) begin
      v.rd1 = 1'($urandom_range(0, 1)); v.wr1 = ($urandom_range(0, 3) == 0);
      v.rd2 = 1'($urandom_range(0, 1)); v.wr2 = ($urandom_range(0, 3) == 0);
      v.a1 = 8'($urandom_range(0, 7)); v.a2 = 8'($urandom_range(0, 7));
      v.d1 = $urandom; v.d2 = $urandom;
      v.fl = ($urandom_range(0, 3) == 0);
      model_pair(v, m1, m2);
      run_pair(v, m1, m2, model_conf, $sformatf("rnd%0d", i));
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final", "mem_diff_words", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
